// File: rtl/user_sobel_core.sv
// Sobel gradient-magnitude core: collects the 8 neighbours of a 3x3 window and emits sat8(|Gx|+|Gy|).
// Optional build macro USER_SOBEL_THRESHOLD_EN turns the result into a binary edge map against thresh_i.
module user_sobel_core #(
  parameter int PixW = 8,
  parameter int CntW = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic            pix_valid_i,
  output logic            pix_ready_o,
  input  logic [PixW-1:0] pix_data_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [PixW-1:0] res_data_o,
`ifdef USER_SOBEL_THRESHOLD_EN
  input  logic [PixW-1:0] thresh_i,
`endif
  output logic [CntW-1:0] res_cnt_o
);

  localparam int GW = PixW + 3;
  localparam logic [PixW-1:0] PixMax = '1;

  // Window slot order matches arrival order: TL TC TR ML MR BL BC BR.
  localparam int TL = 0, TC = 1, TR = 2, ML = 3, MR = 4, BL = 5, BC = 6, BR = 7;

  typedef enum logic [1:0] {
    COLLECT,
    COMPUTE,
    OUTPUT
  } state_t;

  state_t          state;
  logic [2:0]      idx;
  logic [PixW-1:0] win [8];

  logic [GW-1:0]   pos_x, neg_x, pos_y, neg_y;
  logic [GW-1:0]   abs_x, abs_y, mag;
  logic [PixW-1:0] sat, result;

  // Gradients kept as unsigned positive/negative halves; |a-b| avoids signed arithmetic.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    pos_x  = GW'(win[TR]) + GW'({win[MR], 1'b0}) + GW'(win[BR]);
    neg_x  = GW'(win[TL]) + GW'({win[ML], 1'b0}) + GW'(win[BL]);
    pos_y  = GW'(win[BL]) + GW'({win[BC], 1'b0}) + GW'(win[BR]);
    neg_y  = GW'(win[TL]) + GW'({win[TC], 1'b0}) + GW'(win[TR]);
    abs_x  = (pos_x >= neg_x) ? pos_x - neg_x : neg_x - pos_x;
    abs_y  = (pos_y >= neg_y) ? pos_y - neg_y : neg_y - pos_y;
    mag    = abs_x + abs_y;
    sat    = (mag > GW'(PixMax)) ? PixMax : mag[PixW-1:0];
    result = sat;
`ifdef USER_SOBEL_THRESHOLD_EN
    result = (sat >= thresh_i) ? PixMax : '0;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= COLLECT;
      idx         <= '0;
      pix_ready_o <= 1'b1;
      res_valid_o <= 1'b0;
      res_data_o  <= '0;
      res_cnt_o   <= '0;
      // NOTE: the window store is cleared too, so no stale pixel survives a reset.
      for (int i = 0; i < 8; i++) win[i] <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (clear_i) begin
            idx <= '0;
          end else if (pix_valid_i) begin
            win[idx] <= pix_data_i;
            idx      <= idx + 3'd1;
            if (idx == 3'd7) begin
              state       <= COMPUTE;
              pix_ready_o <= 1'b0;
            end
          end
        end
        COMPUTE: begin
          res_data_o  <= result;
          res_valid_o <= 1'b1;
          state       <= OUTPUT;
        end
        OUTPUT: begin
          if (res_ready_i) begin
            res_cnt_o   <= res_cnt_o + 1'b1;
            res_valid_o <= 1'b0;
            pix_ready_o <= 1'b1;
            state       <= COLLECT;
          end
        end
        default: begin
          state       <= COLLECT;
          idx         <= '0;
          pix_ready_o <= 1'b1;
          res_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
